// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. It drives the register enables and bubble
// flushes, drains the pipeline on halt, and runs a memory-wait watchdog and a stall counter.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        ex_memread,
    input  logic        ex_regwrite,
    input  logic [2:0]  ex_rd,
    input  logic        ex_br_taken,
    input  logic        mem_req,
    input  logic        mem_done,
    input  logic        mem_halt,
    input  logic        imem_stall,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StDrain,
        StHalted
    } stateT;

    stateT       stateQ, stateD;
    logic [15:0] waitQ, waitD;
    logic [15:0] stallCntQ, stallCntD;
    logic        errQ, errD;

    logic        memStall;
    logic        loadUse;
    logic [16:0] waitNext;
    logic        timeoutHit;

    assign memStall = mem_req & ~mem_done;

    assign loadUse = id_valid & ex_memread & ex_regwrite &
                     ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));

    // One extra bit so a full 16-bit wait count cannot wrap past the limit.
    assign waitNext   = {1'b0, waitQ} + 17'd1;
    assign timeoutHit = waitNext >= 17'(MEM_TIMEOUT);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        stateD      = stateQ;
        waitD       = waitQ;
        errD        = errQ;

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            unique case (stateQ)
                StHalted: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                end
                StDrain: begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    stateD   = StHalted;
                end
                StRun, StMemWait: begin
                    if (memStall) begin
                        // Freeze everything up to MEM; WB receives bubbles.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_en    = 1'b0;
                        memwb_flush = 1'b1;
                        waitD       = waitNext[15:0];
                        if (timeoutHit) begin
                            errD   = 1'b1;
                            stateD = StHalted;
                        end else begin
                            stateD = StMemWait;
                        end
                    end else begin
                        stateD = StRun;
                        waitD  = '0;
                        if (mem_halt) begin
                            pc_en       = 1'b0;
                            ifid_flush  = 1'b1;
                            idex_flush  = 1'b1;
                            exmem_flush = 1'b1;
                            stateD      = StDrain;
                        end else if (ex_br_taken) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (loadUse) begin
                            // Also covers imem_stall: IF/ID must hold the dependent instruction.
                            pc_en      = 1'b0;
                            ifid_en    = 1'b0;
                            idex_flush = 1'b1;
                        end else if (imem_stall) begin
                            pc_en      = 1'b0;
                            ifid_flush = 1'b1;
                        end
                    end
                end
                default: begin
                    stateD = StRun;
                end
            endcase
        end
    end

    always_comb begin
        stallCntD = stallCntQ;
        if (!pc_en && (stateQ != StHalted) && (stallCntQ != 16'hFFFF)) begin
            stallCntD = stallCntQ + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StRun;
            waitQ     <= '0;
            stallCntQ <= '0;
            errQ      <= 1'b0;
        end else begin
            stateQ    <= stateD;
            waitQ     <= waitD;
            stallCntQ <= stallCntD;
            errQ      <= errD;
        end
    end

    assign halted    = (stateQ == StHalted);
    assign err       = errQ;
    assign stall_cnt = stallCntQ;

endmodule
